bcd_counter_chain: RTL and testbench



---
 rtl/counter_pkg.sv | 43 ++++
 rtl/bcd_counter_digit.sv | 54 +++++
 rtl/bcd_counter_chain.sv | 87 ++++++++
 tb/tb_bcd_counter_chain.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and the single-digit step function used by every counter cell.
package counter_pkg;

  localparam int BCD_MODULUS = 10;
  localparam int MAX_DW      = 16;

  typedef logic [MAX_DW-1:0] digit_t;

  typedef struct packed {
    digit_t value;
    logic   term;
  } step_t;

  // term is the carry/borrow into the next digit. An illegal digit counting up
  // still carries, while counting down it only clamps to MODULUS-1.
  function automatic step_t digit_next(input digit_t value, input logic up,
                                       input int modulus);
    step_t  r;
    digit_t top;
    top     = digit_t'(modulus - 1);
    r.value = '0;
    r.term  = 1'b0;
    if (up) begin
      if (value >= top) begin
        r.value = '0;
        r.term  = 1'b1;
      end else begin
        r.value = value + digit_t'(1);
      end
    end else begin
      if (value == '0) begin
        r.value = top;
        r.term  = 1'b1;
      end else if (value > top) begin
        r.value = top;
      end else begin
        r.value = value - digit_t'(1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter_digit.sv
// One counter digit: register with load/step and its terminal/carry flags.
module bcd_counter_digit
  import counter_pkg::*;
#(
  parameter int DW      = 4,
  parameter int MODULUS = BCD_MODULUS
) (
  input  logic          cp,
  input  logic          mr,
  input  logic          en,
  input  logic          up,
  input  logic          ld,
  input  logic [DW-1:0] pd,
  output logic [DW-1:0] q,
  output logic [DW-1:0] q_nxt,
  output logic          dtc,
  output logic          carry
);

  localparam logic [DW-1:0] TOP = DW'(MODULUS - 1);

  logic [DW-1:0] digit_q, digit_d;
  step_t         step;

  always_comb begin
    step    = digit_next(digit_t'(digit_q), up, MODULUS);
    digit_d = digit_q;
    if (ld) begin
      digit_d = pd;
    end else if (en) begin
      digit_d = step.value[DW-1:0];
    end
  end

  // Only the low DW bits of the shared-width step result are meaningful.
  if (DW < MAX_DW) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^step.value[MAX_DW-1:DW];
  end

  always_ff @(posedge cp) begin
    if (mr) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign q     = digit_q;
  assign q_nxt = mr ? '0 : digit_d;
  assign dtc   = up ? (digit_q == TOP) : (digit_q == '0);
  assign carry = step.term;

endmodule

// File: rtl/bcd_counter_chain.sv
// Cascaded multi-digit modulo counter with load, up/down, compare-match and wrap pulse.
module bcd_counter_chain
  import counter_pkg::*;
#(
  parameter int DIGITS  = 3,
  parameter int MODULUS = BCD_MODULUS,
  parameter int DW      = 4
) (
  input  logic                 cp,
  input  logic                 mr,
  input  logic                 pe_n,
  input  logic [DIGITS*DW-1:0] p,
  input  logic                 cep,
  input  logic                 cet,
  input  logic                 up,
  input  logic [DIGITS*DW-1:0] cmp,
  output logic [DIGITS*DW-1:0] q,
  output logic                 tc,
  output logic [DIGITS-1:0]    dtc,
  output logic                 match,
  output logic                 wrap
);

  if ((2 ** DW) < MODULUS || MODULUS < 2 || DW > MAX_DW) begin : g_bad_modulus
    $fatal(1, "bcd_counter_chain: MODULUS must be in 2..2**DW and DW <= MAX_DW");
  end
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $fatal(1, "bcd_counter_chain: DIGITS must be in 1..8");
  end

  logic [DIGITS:0]      chain_en;
  logic [DIGITS-1:0]    carry;
  logic [DIGITS*DW-1:0] q_nxt;
  logic                 count;
  logic                 all_dtc;
  logic                 match_q, match_d;
  logic                 wrap_q, wrap_d;

  assign count       = cep & cet;
  assign chain_en[0] = count;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    bcd_counter_digit #(
      .DW      (DW),
      .MODULUS (MODULUS)
    ) u_digit (
      .cp    (cp),
      .mr    (mr),
      .en    (chain_en[gi]),
      .up    (up),
      .ld    (~pe_n),
      .pd    (p[gi*DW +: DW]),
      .q     (q[gi*DW +: DW]),
      .q_nxt (q_nxt[gi*DW +: DW]),
      .dtc   (dtc[gi]),
      .carry (carry[gi])
    );
    assign chain_en[gi+1] = chain_en[gi] & carry[gi];
  end

  assign all_dtc = &dtc;
  assign tc      = cet & all_dtc;

  // Load cycles clear both flags; otherwise match looks at the value q takes next.
  always_comb begin
    match_d = 1'b0;
    wrap_d  = 1'b0;
    if (pe_n) begin
      match_d = (q_nxt == cmp);
      wrap_d  = count & all_dtc;
    end
  end

  always_ff @(posedge cp) begin
    if (mr) begin
      match_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      match_q <= match_d;
      wrap_q  <= wrap_d;
    end
  end

  assign match = match_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Directed-vector bench for the 3-digit BCD counter chain.
module tb_bcd_counter_chain;

  logic        cp, mr, pe_n, cep, cet, up;
  logic [11:0] p, cmp, q;
  logic        tc, match, wrap;
  logic [2:0]  dtc;
  int          total, bad;

  bcd_counter_chain #(.DIGITS(3), .MODULUS(10), .DW(4)) dut (
    .cp(cp), .mr(mr), .pe_n(pe_n), .p(p), .cep(cep), .cet(cet), .up(up),
    .cmp(cmp), .q(q), .tc(tc), .dtc(dtc), .match(match), .wrap(wrap)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  task automatic test_reset();
    mr = 1; pe_n = 1; cep = 1; cet = 1; up = 1; p = 12'h000; cmp = 12'hFFF;
    tick(); tick();
    total++; if (q !== 12'h000) begin bad++; $display("FAIL reset_q got=%h want=000", q); end
    total++; if (match !== 1'b0) begin bad++; $display("FAIL reset_match got=%b want=0", match); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b want=0", wrap); end
    mr = 0; cep = 0;
    tick();
    total++; if (q !== 12'h000) begin bad++; $display("FAIL hold_q got=%h want=000", q); end
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL hold_tc got=%b want=0", tc); end
    $display("reset/hold: q=%h tc=%b match=%b wrap=%b", q, tc, match, wrap);
  endtask

  task automatic test_up_rollover();
    up = 1; pe_n = 0; p = 12'h998; cep = 1; cet = 1;
    tick();
    pe_n = 1;
    total++; if (q !== 12'h998) begin bad++; $display("FAIL up_load got=%h want=998", q); end
    total++; if (dtc !== 3'b110) begin bad++; $display("FAIL up_dtc998 got=%b want=110", dtc); end
    tick();
    total++; if (q !== 12'h999) begin bad++; $display("FAIL up_999 got=%h want=999", q); end
    total++; if (tc !== 1'b1) begin bad++; $display("FAIL up_tc999 got=%b want=1", tc); end
    total++; if (dtc !== 3'b111) begin bad++; $display("FAIL up_dtc999 got=%b want=111", dtc); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL up_wrap999 got=%b want=0", wrap); end
    tick();
    total++; if (q !== 12'h000) begin bad++; $display("FAIL up_000 got=%h want=000", q); end
    total++; if (wrap !== 1'b1) begin bad++; $display("FAIL up_wrap000 got=%b want=1", wrap); end
    total++; if (dtc !== 3'b000) begin bad++; $display("FAIL up_dtc000 got=%b want=000", dtc); end
    tick();
    total++; if (q !== 12'h001) begin bad++; $display("FAIL up_001 got=%h want=001", q); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL up_wrap001 got=%b want=0", wrap); end
    $display("up rollover: q=%h wrap=%b", q, wrap);
  endtask

  task automatic test_down_borrow();
    up = 0; pe_n = 0; p = 12'h100; cep = 1; cet = 1;
    tick();
    pe_n = 1;
    total++; if (dtc !== 3'b011) begin bad++; $display("FAIL dn_dtc100 got=%b want=011", dtc); end
    tick();
    total++; if (q !== 12'h099) begin bad++; $display("FAIL dn_099 got=%h want=099", q); end
    tick();
    total++; if (q !== 12'h098) begin bad++; $display("FAIL dn_098 got=%h want=098", q); end
    pe_n = 0; p = 12'h000;
    tick();
    pe_n = 1;
    total++; if (tc !== 1'b1) begin bad++; $display("FAIL dn_tc000 got=%b want=1", tc); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL dn_wrapload got=%b want=0", wrap); end
    tick();
    total++; if (q !== 12'h999) begin bad++; $display("FAIL dn_999 got=%h want=999", q); end
    total++; if (wrap !== 1'b1) begin bad++; $display("FAIL dn_wrap999 got=%b want=1", wrap); end
    tick();
    total++; if (q !== 12'h998) begin bad++; $display("FAIL dn_998 got=%h want=998", q); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL dn_wrap998 got=%b want=0", wrap); end
    $display("down borrow: q=%h wrap=%b", q, wrap);
  endtask

  task automatic test_enable();
    up = 1; pe_n = 0; p = 12'h999; cep = 1; cet = 0;
    tick();
    pe_n = 1;
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL en_tc_cet0 got=%b want=0", tc); end
    tick();
    total++; if (q !== 12'h999) begin bad++; $display("FAIL en_hold_cet0 got=%h want=999", q); end
    cet = 1; cep = 0;
    #1;
    total++; if (tc !== 1'b1) begin bad++; $display("FAIL en_tc_cep0 got=%b want=1", tc); end
    tick();
    total++; if (q !== 12'h999) begin bad++; $display("FAIL en_hold_cep0 got=%h want=999", q); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL en_wrap_hold got=%b want=0", wrap); end
    cep = 1;
    tick();
    total++; if (q !== 12'h000) begin bad++; $display("FAIL en_both got=%h want=000", q); end
    total++; if (wrap !== 1'b1) begin bad++; $display("FAIL en_wrap got=%b want=1", wrap); end
    $display("enable gating: q=%h tc=%b wrap=%b", q, tc, wrap);
  endtask

  task automatic test_illegal_priority();
    up = 1; pe_n = 0; p = 12'h00C; cep = 1; cet = 1;
    tick();
    pe_n = 1;
    total++; if (q !== 12'h00C) begin bad++; $display("FAIL ill_load got=%h want=00c", q); end
    total++; if (dtc[0] !== 1'b0) begin bad++; $display("FAIL ill_dtc0 got=%b want=0", dtc[0]); end
    tick();
    total++; if (q !== 12'h010) begin bad++; $display("FAIL ill_step got=%h want=010", q); end
    mr = 1; pe_n = 0; p = 12'h555;
    tick();
    mr = 0; pe_n = 1; cep = 0;
    total++; if (q !== 12'h000) begin bad++; $display("FAIL prio_mr got=%h want=000", q); end
    total++; if (match !== 1'b0) begin bad++; $display("FAIL prio_match got=%b want=0", match); end
    $display("illegal/priority: q=%h", q);
  endtask

  task automatic test_match();
    up = 1; cmp = 12'h005; pe_n = 0; p = 12'h003; cep = 1; cet = 1;
    tick();
    pe_n = 1;
    total++; if (match !== 1'b0) begin bad++; $display("FAIL m_003 got=%b want=0", match); end
    tick();
    total++; if (match !== 1'b0) begin bad++; $display("FAIL m_004 got=%b want=0", match); end
    tick();
    total++; if (q !== 12'h005) begin bad++; $display("FAIL m_q005 got=%h want=005", q); end
    total++; if (match !== 1'b1) begin bad++; $display("FAIL m_005 got=%b want=1", match); end
    tick();
    cep = 0; cmp = 12'h006;
    total++; if (match !== 1'b0) begin bad++; $display("FAIL m_006 got=%b want=0", match); end
    tick();
    total++; if (q !== 12'h006) begin bad++; $display("FAIL m_hold_q got=%h want=006", q); end
    total++; if (match !== 1'b1) begin bad++; $display("FAIL m_cmpchg got=%b want=1", match); end
    $display("match: q=%h match=%b", q, match);
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_up_rollover();
    test_down_borrow();
    test_enable();
    test_illegal_priority();
    test_match();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
